// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx - PS/2 keyboard receiver.
//
// Synchronises and glitch-filters the PS/2 clock/data lines, deframes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop), optionally
// swallows break sequences (F0 xx) and presents each accepted byte with a
// one-cycle strobe suitable for the downstream shift-register stage.
//
// Parameters:
//   TIMEOUT_CYCLES  clk cycles without a PS/2 falling edge before an
//                   in-progress frame is aborted
//   FILTER_BREAK    1: drop F0 and the byte after it; 0: output every byte
// Ports:
//   clk         system clock
//   rst         synchronous active-low reset
//   ps2_clk     asynchronous PS/2 clock line
//   ps2_data    asynchronous PS/2 data line
//   code        last output byte, held between strobes
//   code_valid  one-cycle strobe, code is new in the same cycle
//   frame_err   one-cycle pulse on parity, stop-bit or timeout error
//   busy        high while a frame is in progress
module ps2_scan_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit FILTER_BREAK   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    clk_sync, dat_sync;
  logic [3:0]    hist;
  logic          fall, sdata;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_ok_q, par_ok_d;
  logic          brk_q, brk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic [7:0]    code_d;
  logic          cv_d, fe_d;

  // Line front end. Flops reset to 1 to match the idle-high bus so that
  // reset release never fabricates an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      hist     <= 4'b1111;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      hist     <= {hist[2:0], clk_sync[1]};
    end
  end

  // Two stable highs followed by two stable lows: single-cycle pulses in
  // either direction can never form this pattern.
  assign fall  = (hist == 4'b1100);
  assign sdata = dat_sync[1];
  assign busy  = (state_q != IDLE);

  assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_LIM);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_ok_d  = par_ok_q;
    brk_d     = brk_q;
    code_d    = code;
    cv_d      = 1'b0;
    fe_d      = 1'b0;

    // Saturating idle counter; cleared by activity or when idle.
    if (state_q == IDLE || fall)
      tmo_d = '0;
    else if (tmo_q != TMO_LIM)
      tmo_d = tmo_q + 1'b1;
    else
      tmo_d = tmo_q;

    // Timeout wins over a coincident edge: the frame is already stale.
    if (tmo_hit) begin
      state_d = IDLE;
      fe_d    = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!sdata) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end
        end
        DATA: begin
          shreg_d = {sdata, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7)
            state_d = PARITY;
          else
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        PARITY: begin
          par_ok_d = ^{shreg_q, sdata};
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (sdata && par_ok_q) begin
            // F0 always (re)arms the filter, so F0 F0 xx still eats xx.
            if (FILTER_BREAK && shreg_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (FILTER_BREAK && brk_q) begin
              brk_d = 1'b0;
            end else begin
              code_d = shreg_q;
              cv_d   = 1'b1;
            end
          end else begin
            fe_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      par_ok_q   <= 1'b0;
      brk_q      <= 1'b0;
      tmo_q      <= '0;
      code       <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_ok_q   <= par_ok_d;
      brk_q      <= brk_d;
      tmo_q      <= tmo_d;
      code       <= code_d;
      code_valid <= cv_d;
      frame_err  <= fe_d;
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
module tb_ps2_scan_rx;

  localparam int T = 300;  // short timeout keeps the run small
  localparam int H = 8;    // clk cycles per PS/2 half period

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code, nf_code;
  logic       code_valid, frame_err, busy;
  logic       nf_code_valid, nf_frame_err, nf_busy;

  ps2_scan_rx #(.TIMEOUT_CYCLES(T), .FILTER_BREAK(1'b1)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .code_valid(code_valid), .frame_err(frame_err), .busy(busy));

  ps2_scan_rx #(.TIMEOUT_CYCLES(T), .FILTER_BREAK(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(nf_code), .code_valid(nf_code_valid), .frame_err(nf_frame_err),
    .busy(nf_busy));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled away from the active edge.
  int cv_cnt = 0, fe_cnt = 0, busy_cnt = 0, excl = 0;
  logic [7:0] nf_q[$];
  always @(negedge clk) begin
    if (code_valid) cv_cnt <= cv_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (code_valid && frame_err) excl <= excl + 1;
    if (nf_code_valid) nf_q.push_back(nf_code);
  end

  int errors = 0, checks = 0;
  int last_drop = 0;
  logic mid_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    last_drop = cyc;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stop);
    send_bit(1'b0);
    mid_busy = busy;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ pflip);
    send_bit(stop);
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         pflip;
    bit         stop;
    int         n_cv;
    int         n_fe;
    logic [7:0] code;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int cv0, fe0, b0, nq0, err_cyc, fall_cyc, delta;
    logic [7:0] gb;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
    vecs[1] = '{8'h32, 1'b0, 1'b1, 1, 0, 8'h32};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h32};  // parity error keeps 0x32
    vecs[3] = '{8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1, 0, 8'hFF};
    vecs[6] = '{8'h55, 1'b0, 1'b0, 0, 1, 8'hFF};  // stop bit 0
    vecs[7] = '{8'hA5, 1'b0, 1'b1, 1, 0, 8'hA5};

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_code", code, 8'h00);
    chk("rst_code_valid", code_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_frame(vecs[i].d, vecs[i].pflip, vecs[i].stop);
      chk($sformatf("v%0d_cv", i), cv_cnt - cv0, vecs[i].n_cv);
      chk($sformatf("v%0d_fe", i), fe_cnt - fe0, vecs[i].n_fe);
      chk($sformatf("v%0d_code", i), code, vecs[i].code);
      chk($sformatf("v%0d_busy_mid", i), mid_busy, 1'b1);
      chk($sformatf("v%0d_busy_end", i), busy, 1'b0);
    end

    // Glitch: 1-cycle low pulse on ps2_clk between data bits 3 and 4
    gb = 8'h1C;
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(gb[i]);
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    @(negedge clk) ps2_clk = 1'b1;
    for (int i = 4; i < 8; i++) send_bit(gb[i]);
    send_bit(~^gb);
    send_bit(1'b1);
    repeat (20) @(negedge clk);
    chk("glitch_cv", cv_cnt - cv0, 1);
    chk("glitch_fe", fe_cnt - fe0, 0);
    chk("glitch_code", code, 8'h1C);

    // Timeout: start + 5 data bits then idle-high
    fe0 = fe_cnt; cv0 = cv_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    fall_cyc = last_drop + 4;
    err_cyc = -1;
    for (int k = 0; k < T + 60; k++) begin
      @(negedge clk);
      if (frame_err) begin
        err_cyc = cyc;
        chk("tmo_busy_at_err", busy, 1'b0);
        break;
      end
    end
    delta = err_cyc - fall_cyc;
    checks++;
    if (err_cyc < 0 || delta < T + 1 || delta > T + 3) begin
      errors++;
      $display("FAIL tmo_latency: got %0d cycles after fall, expected %0d..%0d",
               delta, T + 1, T + 3);
    end
    repeat (5) @(negedge clk);
    chk("tmo_fe", fe_cnt - fe0, 1);
    chk("tmo_cv", cv_cnt - cv0, 0);
    cv0 = cv_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("tmo_recover_cv", cv_cnt - cv0, 1);
    chk("tmo_recover_code", code, 8'h1C);

    // Break filter: F0 1C 32
    cv0 = cv_cnt; nq0 = nf_q.size();
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    chk("brk_cv", cv_cnt - cv0, 1);
    chk("brk_code", code, 8'h32);
    chk("nf_cnt", nf_q.size() - nq0, 3);
    if (nf_q.size() >= nq0 + 3) begin
      chk("nf_b0", nf_q[nq0], 8'hF0);
      chk("nf_b1", nf_q[nq0 + 1], 8'h1C);
      chk("nf_b2", nf_q[nq0 + 2], 8'h32);
    end

    // F0 F0 1C E0: repeated F0 keeps the filter armed
    cv0 = cv_cnt;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1);
    chk("brk2_cv", cv_cnt - cv0, 1);
    chk("brk2_code", code, 8'hE0);

    // F0, bad frame, 1C, 4D: frame error leaves the filter armed
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h4D, 1'b0, 1'b1);
    chk("brk3_cv", cv_cnt - cv0, 1);
    chk("brk3_fe", fe_cnt - fe0, 1);
    chk("brk3_code", code, 8'h4D);

    // Reset mid-frame after data bit 4
    cv0 = cv_cnt; fe0 = fe_cnt;
    gb = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(gb[i]);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    chk("mrst_code", code, 8'h00);
    chk("mrst_cv", code_valid, 1'b0);
    chk("mrst_fe", frame_err, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    b0 = busy_cnt;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    repeat (20) @(negedge clk);
    chk("mrst_tail_cv", cv_cnt - cv0, 0);
    chk("mrst_tail_fe", fe_cnt - fe0, 0);
    chk("mrst_tail_busy", busy_cnt - b0, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("mrst_next_cv", cv_cnt - cv0, 1);
    chk("mrst_next_code", code, 8'h1C);

    chk("exclusive", excl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a stimulus task ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_scan_rx.md
# ps2_scan_rx

Receives the PS/2 keyboard serial stream and turns it into validated make-code bytes for the display path. It synchronises and filters the external `ps2_clk`/`ps2_data` lines, then deframes 11-bit PS/2 frames and checks parity and stop bit. Break sequences (F0 xx) are optionally suppressed. Each accepted byte is presented with a single-cycle strobe that drives the `data`/`shren` inputs of the 8-character shift-register stage directly downstream.

## Interface
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles without a falling edge before an in-progress frame is aborted (1 ms at 50 MHz).
- `FILTER_BREAK`, default 1: 1 = suppress F0 and the byte following it; 0 = output every accepted byte.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-low; sampled on the rising edge of `clk`.
- `ps2_clk`  in  1  asynchronous PS/2 clock line from the keyboard.
- `ps2_data`  in  1  asynchronous PS/2 data line from the keyboard.
- `code`  out  8  last output byte; held between strobes.
- `code_valid`  out  1  one-cycle pulse; `code` is new in the same cycle. Connects to the downstream `shren`.
- `frame_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.
- `busy`  out  1  high while a frame is in progress (state != IDLE).

## Operation
- **Synchronisation.** `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser.
- **Clock filtering.** The synchronised `ps2_clk` feeds a 4-bit history register (oldest bit on the left).
- **Falling edge.** `fall` is asserted for one cycle when the history equals 1100. Any low or high pulse shorter than 2 cycles never produces `fall`.
- **Data sampling.** `ps2_data` (synchronised) is sampled in the `fall` cycle.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 (start bit), go to DATA with bit count 0. On `fall` with data=1, stay in IDLE and ignore the bit.
  - DATA: on `fall`, shift the bit in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, latch `par_ok` = (ones in 8 data bits + parity bit) is odd. Go to STOP.
  - STOP: on `fall`, return to IDLE. If stop bit = 1 and `par_ok` = 1, the byte is accepted. Otherwise pulse `frame_err` and discard the byte.
- **Timeout.**
  - A counter clears on every `fall` and in IDLE, and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES` in a non-IDLE state: pulse `frame_err`, discard the partial byte and go to IDLE.
  - The counter saturates and does not wrap.
- **Break filter (`FILTER_BREAK`=1).**
  - Accepted F0: set `brk` and produce no output.
  - Next accepted byte while `brk`=1: clear `brk` and produce no output.
  - F0 received while `brk`=1: `brk` stays set.
  - E0 and all other bytes are output normally.
  - A frame error does not clear `brk`.
- **Output.** An accepted, unfiltered byte loads `code` and pulses `code_valid` in the same cycle.
- **Exclusivity.** `code_valid` and `frame_err` are never high in the same cycle.

## Timing
- **Reset values:** `code`=0x00, `code_valid`=0, `frame_err`=0, `busy`=0, state IDLE, `brk`=0, timeout counter 0, synchroniser and history flops = 1 (idle-high line).
- **Reset mid-frame:** abandons the frame with no output and no `frame_err`. Takes effect on the first `clk` edge where `rst`=0.
- **Edge latency:** the external `ps2_clk` falling edge produces `fall` 4 `clk` cycles later (2 synchroniser + 2 history).
- **Output latency:** `code_valid`/`frame_err` are registered and assert 1 cycle after the stop-bit `fall` cycle.
- **Strobe spacing:** at least 1 frame time apart; the downstream stage needs no back-pressure.
- **`busy`:** rises the cycle after the start-bit `fall`. Falls together with the `code_valid`/`frame_err` pulse, or the cycle after the timeout fires.
- **Supported rate:** PS/2 clock 10–16.7 kHz with `clk` ≥ 1 MHz; at least 4 `clk` cycles per PS/2 half-period.

## Test plan
- **Good frame.** Frame 0x1C (data LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1) -> exactly one `code_valid` pulse with `code`=0x1C; `frame_err` stays 0; `busy` high during the frame and low after.
- **Parity error.** 0x1C with parity bit 1, after a good 0x32 -> one `frame_err` pulse, no `code_valid`, `code` stays 0x32.
- **Break filter.** With `FILTER_BREAK`=1, send F0, 1C, 32 -> exactly one `code_valid` with `code`=0x32. With `FILTER_BREAK`=0, the same sequence -> three pulses: F0, 1C, 32.
- **Timeout.** Send start + 5 data bits, then hold `ps2_clk` high -> `frame_err` pulse `TIMEOUT_CYCLES` cycles after the last `fall`, `busy` drops. A following good frame 0x1C is received correctly.
- **Reset mid-frame.** Assert `rst`=0 for 1 cycle after bit 4 -> all outputs return to reset values, no strobe. Remaining edges of the aborted frame (data=1 at start) are ignored, then the next good 0x1C is accepted.
- **Glitch rejection and stop-bit error.** A 1-cycle low glitch on `ps2_clk` mid-frame -> no extra bit shifted, byte correct. Stop bit = 0 -> `frame_err`, no `code_valid`.
